riscv_div_unit: RTL and testbench

//   Multi-cycle iterative divider for RV32M DIV/DIVU/REM/REMU: the inverse-operation companion to the
//   ALU multiply path. Sits beside the ALU in EX; the pipeline issues start, stalls on busy, and

---
 rtl/riscv_div_unit_pkg.sv | 29 ++
 rtl/riscv_div_unit_div_step.sv | 25 ++
 rtl/riscv_div_unit.sv | 142 ++++++++++++++
 tb/tb_riscv_div_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_div_unit_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package riscv_div_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned DIV_ITERS  = 32;

    typedef enum logic [1:0] {
        DT_DIV  = 2'b00,
        DT_DIVU = 2'b01,
        DT_REM  = 2'b10,
        DT_REMU = 2'b11
    } div_type_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_e;

    function automatic logic is_signed_op(input div_type_e t);
        return ~t[0];
    endfunction

    function automatic logic is_rem_op(input div_type_e t);
        return t[1];
    endfunction

endpackage

// File: rtl/riscv_div_unit_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract divisor if it fits.
module riscv_div_unit_div_step
    import riscv_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] rem_shift_c;

    always_comb begin
        rem_shift_c = {rem_in, quo_in[XLEN-1]};
        if (rem_shift_c >= {1'b0, divisor}) begin
            rem_out = XLEN'(rem_shift_c - {1'b0, divisor});
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = rem_shift_c[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/riscv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU multi-cycle restoring divider.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the CALC phase.
module riscv_div_unit
    import riscv_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      DivType,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] DivOut
);

    div_state_e            state_q, state_d;
    div_type_e             type_q;
    logic [ITER_CNT_W-1:0] iter_q;
    logic [XLEN-1:0]       rem_q, quo_q, divisor_q, dividend_q;
    logic                  neg_q, dneg_q, zero_q, ovf_q;

    logic                  accept_c, fix_fire_c, early_c;
    logic                  signed_c, op1_neg_c, op2_neg_c, zero_c, ovf_c;
    logic [XLEN-1:0]       abs1_c, abs2_c;
    logic [XLEN-1:0]       step_rem_c, step_quo_c;
    logic [XLEN-1:0]       quo_res_c, rem_res_c, result_c;

    // Operand conditioning at accept time
    always_comb begin
        signed_c  = is_signed_op(div_type_e'(DivType));
        op1_neg_c = signed_c & Operand1[XLEN-1];
        op2_neg_c = signed_c & Operand2[XLEN-1];
        abs1_c    = op1_neg_c ? -Operand1 : Operand1;
        abs2_c    = op2_neg_c ? -Operand2 : Operand2;
        zero_c    = (Operand2 == '0);
        ovf_c     = signed_c && (Operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (Operand2 == '1);
`ifdef DIV_EARLY_OUT_EN
        early_c   = zero_c | ovf_c;
`else
        early_c   = 1'b0;
`endif
    end

    riscv_div_unit_div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (step_rem_c),
        .quo_out (step_quo_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and control; busy also covers the done cycle, so IDLE ignores start then
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        fix_fire_c = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start && !flush && !busy) begin
                    accept_c = 1'b1;
                    state_d  = early_c ? DIV_FIX : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (flush)                                         state_d = DIV_IDLE;
                else if (iter_q == ITER_CNT_W'(DIV_ITERS - 1))     state_d = DIV_FIX;
            end
            DIV_FIX: begin
                state_d    = DIV_IDLE;
                fix_fire_c = ~flush;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Sign fix-up with divide-by-zero / overflow overrides
    always_comb begin
        quo_res_c = neg_q  ? -quo_q : quo_q;
        rem_res_c = dneg_q ? -rem_q : rem_q;
        if (zero_q) begin
            quo_res_c = '1;
            rem_res_c = dneg_q ? -dividend_q : dividend_q;
        end
        if (ovf_q) begin
            quo_res_c = {1'b1, {(XLEN-1){1'b0}}};
            rem_res_c = '0;
        end
        result_c = is_rem_op(type_q) ? rem_res_c : quo_res_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q     <= DT_DIV;
            iter_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            neg_q      <= 1'b0;
            dneg_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            DivOut     <= '0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                type_q     <= div_type_e'(DivType);
                iter_q     <= '0;
                rem_q      <= '0;
                quo_q      <= abs1_c;
                divisor_q  <= abs2_c;
                dividend_q <= abs1_c;
                neg_q      <= op1_neg_c ^ op2_neg_c;
                dneg_q     <= op1_neg_c;
                zero_q     <= zero_c;
                ovf_q      <= ovf_c;
                busy       <= 1'b1;
            end else if (flush || done) begin
                busy <= 1'b0;
            end
            if (state_q == DIV_CALC) begin
                rem_q  <= step_rem_c;
                quo_q  <= step_quo_c;
                iter_q <= iter_q + ITER_CNT_W'(1);
            end
            if (fix_fire_c) begin
                DivOut <= result_c;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Scoreboard bench for riscv_div_unit: reference results queued at issue, checked on done.
module tb_riscv_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [1:0]  DivType;
    logic [31:0] Operand1, Operand2;
    logic        busy, done;
    logic [31:0] DivOut;

    riscv_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .DivType  (DivType),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .busy     (busy),
        .done     (done),
        .DivOut   (DivOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          c0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   n_push   = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic special(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return t[1] ? a : 32'hFFFF_FFFF;
        if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return t[1] ? 32'h0 : 32'h8000_0000;
        case (t)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (special(t, a, b)) return 2;
`else
        if (special(t, a, b)) return 34;
`endif
        return 34;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for exactly one cycle; optionally queue the expected result
    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        DivType  = t;
        Operand1 = a;
        Operand2 = b;
        start    = 1'b1;
        if (push) begin
            e.val = model(t, a, b);
            e.c0  = cyc;
            e.lat = latency(t, a, b);
            sb.push_back(e);
            n_push++;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen = 1'b0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk);
            if (n == 0) check("busy_run", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("divout", DivOut, e.val);
                    check("latency", 32'(cyc - e.c0), 32'(e.lat));
                    check("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
        if (!seen) begin
            check("timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        @(negedge clk);
        check("busy_clr", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
        tick();
    endtask

    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        issue(t, a, b, 1'b1);
        wait_done();
    endtask

    logic [31:0] prev;
    int          c0;

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        DivType = 2'b00; Operand1 = '0; Operand2 = '0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_divout", DivOut, 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'h1234_5678, 32'd0);
        run_op(2'b10, 32'd5, 32'd0);
        run_op(2'b00, 32'hFFFF_FFFB, 32'd0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1);

        // Random cases
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(2'($urandom_range(0, 3)), a, b);
        end

        // start while busy is ignored, and later operand changes have no effect
        issue(2'b01, 32'd1000, 32'd9, 1'b1);
        repeat (4) tick();
        issue(2'b00, 32'd50, 32'd5, 1'b0);
        Operand1 = 32'hDEAD_BEEF;
        Operand2 = 32'd3;
        wait_done();

        // flush mid-operation: busy drops next cycle, no done, DivOut held, restart same cycle
        prev = DivOut;
        c0   = cyc;
        issue(2'b01, 32'd1000, 32'd3, 1'b0);
        while (cyc < c0 + 10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_hold", DivOut, prev);
        run_op(2'b11, 32'd1000, 32'd3);

        // async reset mid-operation
        c0 = cyc;
        issue(2'b00, 32'd12345, 32'd11, 1'b0);
        while (cyc < c0 + 20) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_divout", DivOut, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7);

        repeat (40) tick();
        check("done_count", 32'(done_cnt), 32'(n_push));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
